// File: rtl/pipe_ctrl_if.sv
// Hazard-source / PC-control bundle between the pipeline and pipe_ctrl.
// master = pipeline side driving requests, slave = the scheduler.
interface pipe_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              ex_jump_req_i;
    logic [ADDR_W-1:0] ex_jump_addr_i;
    logic [ADDR_W-1:0] ex_pc_i;
    logic              div_busy_i;
    logic              load_use_i;
    logic              irq_req_i;
    logic [ADDR_W-1:0] irq_vector_i;
    logic              mret_req_i;
    logic [ADDR_W-1:0] mepc_i;

    logic              jump_ena_o;
    logic [ADDR_W-1:0] jump_addr_o;
    logic              hold_pc_o;
    logic              hold_if_o;
    logic              hold_id_o;
    logic              flush_if_o;
    logic              flush_id_o;
    logic              irq_ack_o;
    logic              trap_save_o;
    logic [ADDR_W-1:0] trap_mepc_o;

    modport master (
        output ex_jump_req_i, ex_jump_addr_i, ex_pc_i, div_busy_i, load_use_i,
               irq_req_i, irq_vector_i, mret_req_i, mepc_i,
        input  jump_ena_o, jump_addr_o, hold_pc_o, hold_if_o, hold_id_o,
               flush_if_o, flush_id_o, irq_ack_o, trap_save_o, trap_mepc_o
    );

    modport slave (
        input  ex_jump_req_i, ex_jump_addr_i, ex_pc_i, div_busy_i, load_use_i,
               irq_req_i, irq_vector_i, mret_req_i, mepc_i,
        output jump_ena_o, jump_addr_o, hold_pc_o, hold_if_o, hold_id_o,
               flush_if_o, flush_id_o, irq_ack_o, trap_save_o, trap_mepc_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard scheduler: fixed-priority arbitration of redirects/stalls
// and a trap-entry FSM (save mepc, jump to vector, drain).
module pipe_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk_100MHz,
    input  logic        arst_n,
    pipe_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DIV  = 3'd1,
        TRAP_SAVE = 3'd2,
        TRAP_JUMP = 3'd3,
        FLUSH     = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [2:0]        cnt_reg, cnt_next;
    logic [ADDR_W-1:0] vec_reg, vec_next;
    logic [ADDR_W-1:0] mepc_reg, mepc_next;

    logic              jump_ena;
    logic [ADDR_W-1:0] jump_addr;
    logic              hold_pc, hold_if, hold_id;
    logic              flush_if, flush_id;
    logic              irq_ack, trap_save;

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            vec_reg   <= '0;
            mepc_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            vec_reg   <= vec_next;
            mepc_reg  <= mepc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        vec_next   = vec_reg;
        mepc_next  = mepc_reg;
        jump_ena   = 1'b0;
        jump_addr  = '0;
        hold_pc    = 1'b0;
        hold_if    = 1'b0;
        hold_id    = 1'b0;
        flush_if   = 1'b0;
        flush_id   = 1'b0;
        irq_ack    = 1'b0;
        trap_save  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.irq_req_i && !bus.div_busy_i) begin
                    // A taken branch in EX means execution resumes at its target.
                    mepc_next  = bus.ex_jump_req_i ? bus.ex_jump_addr_i : bus.ex_pc_i;
                    vec_next   = bus.irq_vector_i;
                    irq_ack    = 1'b1;
                    hold_pc    = 1'b1;
                    flush_if   = 1'b1;
                    flush_id   = 1'b1;
                    state_next = TRAP_SAVE;
                end else if (bus.irq_req_i) begin
                    vec_next   = bus.irq_vector_i;
                    irq_ack    = 1'b1;
                    hold_pc    = 1'b1;
                    hold_if    = 1'b1;
                    hold_id    = 1'b1;
                    state_next = WAIT_DIV;
                end else if (bus.mret_req_i) begin
                    jump_ena  = 1'b1;
                    jump_addr = bus.mepc_i;
                    flush_if  = 1'b1;
                    flush_id  = 1'b1;
                end else if (bus.ex_jump_req_i) begin
                    jump_ena  = 1'b1;
                    jump_addr = bus.ex_jump_addr_i;
                    flush_if  = 1'b1;
                    flush_id  = 1'b1;
                end else if (bus.div_busy_i) begin
                    hold_pc = 1'b1;
                    hold_if = 1'b1;
                    hold_id = 1'b1;
                end else if (bus.load_use_i) begin
                    hold_pc  = 1'b1;
                    hold_if  = 1'b1;
                    flush_id = 1'b1;
                end
            end
            WAIT_DIV: begin
                // Interrupt already acknowledged; only the divider matters here.
                hold_pc = 1'b1;
                hold_if = 1'b1;
                hold_id = 1'b1;
                if (!bus.div_busy_i) begin
                    mepc_next  = bus.ex_pc_i;
                    state_next = TRAP_SAVE;
                end
            end
            TRAP_SAVE: begin
                trap_save  = 1'b1;
                hold_pc    = 1'b1;
                flush_if   = 1'b1;
                flush_id   = 1'b1;
                state_next = TRAP_JUMP;
            end
            TRAP_JUMP: begin
                jump_ena   = 1'b1;
                jump_addr  = vec_reg;
                flush_if   = 1'b1;
                flush_id   = 1'b1;
                cnt_next   = 3'(FLUSH_CYCLES - 1);
                state_next = FLUSH;
            end
            FLUSH: begin
                flush_if = 1'b1;
                flush_id = 1'b1;
                if (cnt_reg == 3'd0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort instantly while reset is held, even if inputs are still active.
        if (!arst_n) begin
            jump_ena  = 1'b0;
            jump_addr = '0;
            hold_pc   = 1'b0;
            hold_if   = 1'b0;
            hold_id   = 1'b0;
            flush_if  = 1'b0;
            flush_id  = 1'b0;
            irq_ack   = 1'b0;
            trap_save = 1'b0;
        end
    end

    assign bus.jump_ena_o  = jump_ena;
    assign bus.jump_addr_o = jump_addr;
    assign bus.hold_pc_o   = hold_pc;
    assign bus.hold_if_o   = hold_if;
    assign bus.hold_id_o   = hold_id;
    assign bus.flush_if_o  = flush_if;
    assign bus.flush_id_o  = flush_id;
    assign bus.irq_ack_o   = irq_ack;
    assign bus.trap_save_o = trap_save;
    assign bus.trap_mepc_o = mepc_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: redirects, stalls, trap sequences, reset abort.
// Control outputs are packed as {jump_ena, hold_pc, hold_if, hold_id, flush_if, flush_id, irq_ack, trap_save}.
module tb_pipe_ctrl;

    logic clk_100MHz = 1'b0;
    logic arst_n     = 1'b0;
    int   checks     = 0;
    int   errs       = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    pipe_ctrl_if #(.ADDR_W(32)) bus ();

    pipe_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2)) dut (
        .clk_100MHz (clk_100MHz),
        .arst_n     (arst_n),
        .bus        (bus)
    );

    logic [7:0] outs;
    assign outs = {bus.jump_ena_o, bus.hold_pc_o, bus.hold_if_o, bus.hold_id_o,
                   bus.flush_if_o, bus.flush_id_o, bus.irq_ack_o, bus.trap_save_o};

    task automatic set_idle();
        bus.ex_jump_req_i  = 1'b0;
        bus.ex_jump_addr_i = '0;
        bus.ex_pc_i        = '0;
        bus.div_busy_i     = 1'b0;
        bus.load_use_i     = 1'b0;
        bus.irq_req_i      = 1'b0;
        bus.irq_vector_i   = '0;
        bus.mret_req_i     = 1'b0;
        bus.mepc_i         = '0;
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    // Move to the falling edge, where outputs are sampled.
    task automatic mid();
        @(negedge clk_100MHz);
    endtask

    task automatic test_reset();
        set_idle();
        arst_n = 1'b0;
        mid();
        checks++; if (outs !== 8'h00) begin errs++; $display("FAIL reset_outs: got %h want %h", outs, 8'h00); end
        checks++; if (bus.jump_addr_o !== 32'h0) begin errs++; $display("FAIL reset_jaddr: got %h want %h", bus.jump_addr_o, 32'h0); end
        checks++; if (bus.trap_mepc_o !== 32'h0) begin errs++; $display("FAIL reset_mepc: got %h want %h", bus.trap_mepc_o, 32'h0); end
        #2 arst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_branch();
        bus.ex_jump_req_i  = 1'b1;
        bus.ex_jump_addr_i = 32'h100;
        mid();
        checks++; if (outs !== 8'h8C) begin errs++; $display("FAIL branch_outs: got %h want %h", outs, 8'h8C); end
        checks++; if (bus.jump_addr_o !== 32'h100) begin errs++; $display("FAIL branch_addr: got %h want %h", bus.jump_addr_o, 32'h100); end
        tick();
        set_idle();
        mid();
        checks++; if (outs !== 8'h00) begin errs++; $display("FAIL branch_after: got %h want %h", outs, 8'h00); end
        tick();
        $display("test_branch done");
    endtask

    // Full trap sequence with idle divider; irq held high to prove it is ignored mid-sequence.
    task automatic test_trap(input logic with_jump, input logic [31:0] vec,
                             input logic [31:0] pc, input logic [31:0] jtgt,
                             input logic [31:0] exp_mepc);
        bus.irq_req_i      = 1'b1;
        bus.irq_vector_i   = vec;
        bus.ex_pc_i        = pc;
        bus.ex_jump_req_i  = with_jump;
        bus.ex_jump_addr_i = jtgt;
        mid();
        checks++; if (outs !== 8'h4E) begin errs++; $display("FAIL trap_c0_outs: got %h want %h", outs, 8'h4E); end
        checks++; if (bus.jump_addr_o !== 32'h0) begin errs++; $display("FAIL trap_c0_jaddr: got %h want %h", bus.jump_addr_o, 32'h0); end
        tick();
        bus.ex_jump_req_i = 1'b0;
        bus.irq_vector_i  = 32'hDEAD;
        mid();
        checks++; if (outs !== 8'h4D) begin errs++; $display("FAIL trap_c1_outs: got %h want %h", outs, 8'h4D); end
        checks++; if (bus.trap_mepc_o !== exp_mepc) begin errs++; $display("FAIL trap_c1_mepc: got %h want %h", bus.trap_mepc_o, exp_mepc); end
        tick();
        mid();
        checks++; if (outs !== 8'h8C) begin errs++; $display("FAIL trap_c2_outs: got %h want %h", outs, 8'h8C); end
        checks++; if (bus.jump_addr_o !== vec) begin errs++; $display("FAIL trap_c2_addr: got %h want %h", bus.jump_addr_o, vec); end
        for (int c = 3; c <= 4; c++) begin
            tick();
            bus.mret_req_i = 1'b1;
            mid();
            checks++; if (outs !== 8'h0C) begin errs++; $display("FAIL trap_c%0d_flush: got %h want %h", c, outs, 8'h0C); end
        end
        tick();
        set_idle();
        mid();
        checks++; if (outs !== 8'h00) begin errs++; $display("FAIL trap_c5_idle: got %h want %h", outs, 8'h00); end
        tick();
        $display("test_trap vec=%h mepc=%h done", vec, exp_mepc);
    endtask

    task automatic test_div_wait();
        bus.irq_req_i    = 1'b1;
        bus.irq_vector_i = 32'h300;
        bus.div_busy_i   = 1'b1;
        mid();
        checks++; if (outs !== 8'h72) begin errs++; $display("FAIL div_c0_outs: got %h want %h", outs, 8'h72); end
        tick();
        bus.irq_req_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin
                bus.div_busy_i = 1'b0;
                bus.ex_pc_i    = 32'h48;
            end
            mid();
            checks++; if (outs !== 8'h70) begin errs++; $display("FAIL div_c%0d_wait: got %h want %h", c, outs, 8'h70); end
            tick();
        end
        bus.ex_pc_i = 32'h99;
        mid();
        checks++; if (outs !== 8'h4D) begin errs++; $display("FAIL div_c5_save: got %h want %h", outs, 8'h4D); end
        checks++; if (bus.trap_mepc_o !== 32'h48) begin errs++; $display("FAIL div_c5_mepc: got %h want %h", bus.trap_mepc_o, 32'h48); end
        tick();
        mid();
        checks++; if (bus.jump_addr_o !== 32'h300 || outs !== 8'h8C) begin errs++; $display("FAIL div_c6_jump: got %h/%h want %h/%h", outs, bus.jump_addr_o, 8'h8C, 32'h300); end
        tick();
        tick();
        tick();
        mid();
        checks++; if (outs !== 8'h00) begin errs++; $display("FAIL div_c9_idle: got %h want %h", outs, 8'h00); end
        tick();
        $display("test_div_wait done");
    endtask

    task automatic test_load_use();
        bus.load_use_i = 1'b1;
        bus.div_busy_i = 1'b1;
        mid();
        checks++; if (outs !== 8'h70) begin errs++; $display("FAIL lu_div: got %h want %h", outs, 8'h70); end
        tick();
        bus.div_busy_i = 1'b0;
        mid();
        checks++; if (outs !== 8'h64) begin errs++; $display("FAIL lu_alone: got %h want %h", outs, 8'h64); end
        tick();
        bus.ex_jump_req_i  = 1'b1;
        bus.ex_jump_addr_i = 32'h1C0;
        mid();
        checks++; if (outs !== 8'h8C) begin errs++; $display("FAIL lu_vs_branch: got %h want %h", outs, 8'h8C); end
        tick();
        set_idle();
        $display("test_load_use done");
    endtask

    task automatic test_reset_mid();
        bus.irq_req_i    = 1'b1;
        bus.irq_vector_i = 32'h200;
        bus.ex_pc_i      = 32'h50;
        tick();
        bus.irq_req_i = 1'b0;
        mid();
        checks++; if (outs !== 8'h4D) begin errs++; $display("FAIL rmid_save: got %h want %h", outs, 8'h4D); end
        #1 arst_n = 1'b0;
        #1;
        checks++; if (outs !== 8'h00) begin errs++; $display("FAIL rmid_outs: got %h want %h", outs, 8'h00); end
        checks++; if (bus.trap_mepc_o !== 32'h0) begin errs++; $display("FAIL rmid_mepc: got %h want %h", bus.trap_mepc_o, 32'h0); end
        #1 arst_n = 1'b1;
        tick();
        mid();
        checks++; if (outs !== 8'h00) begin errs++; $display("FAIL rmid_idle: got %h want %h", outs, 8'h00); end
        tick();
        bus.mret_req_i = 1'b1;
        bus.mepc_i     = 32'h300;
        mid();
        checks++; if (outs !== 8'h8C || bus.jump_addr_o !== 32'h300) begin errs++; $display("FAIL rmid_mret: got %h/%h want %h/%h", outs, bus.jump_addr_o, 8'h8C, 32'h300); end
        tick();
        set_idle();
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_branch();
        test_trap(1'b0, 32'h200, 32'h40, 32'h0, 32'h40);
        test_trap(1'b1, 32'h280, 32'h44, 32'h80, 32'h80);
        test_div_wait();
        test_load_use();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control scheduler between the hazard sources (EX branch/jump, divider, load-use detector, interrupt controller, `mret`) and the PC and IF/ID pipeline registers. It arbitrates the competing requests by fixed priority and drives the PC's jump and hold inputs. It also drives the hold and flush controls of the IF/ID stages, and sequences interrupt entry as a multi-cycle trap FSM. The PC honours hold over jump, so this block never asserts both in the same cycle.

## Interface
Parameters:
- `ADDR_W`, 32, instruction address width.
- `FLUSH_CYCLES`, 2, drain cycles after a trap redirect; legal range 1..7.

Ports:
- `clk_100MHz` in 1: clock.
- `arst_n` in 1: reset, asynchronous, active-low.
- `ex_jump_req_i` in 1: EX stage resolved a taken branch or jump.
- `ex_jump_addr_i` in `ADDR_W`: EX redirect target.
- `ex_pc_i` in `ADDR_W`: PC of the instruction in EX.
- `div_busy_i` in 1: divider is mid-operation.
- `load_use_i` in 1: ID detected a load-use hazard.
- `irq_req_i` in 1: interrupt pending, level signal.
- `irq_vector_i` in `ADDR_W`: trap handler address.
- `mret_req_i` in 1: `mret` in EX.
- `mepc_i` in `ADDR_W`: current CSR `mepc`.
- `jump_ena_o` out 1: to PC `jump_ena_i`.
- `jump_addr_o` out `ADDR_W`: to PC `jump_addr_i`.
- `hold_pc_o` out 1: to PC `hold_ena_i`.
- `hold_if_o` out 1: freeze the IF/ID register.
- `hold_id_o` out 1: freeze the ID/EX register.
- `flush_if_o` out 1: bubble the IF/ID register.
- `flush_id_o` out 1: bubble the ID/EX register.
- `irq_ack_o` out 1: one-cycle pulse when the interrupt is accepted.
- `trap_save_o` out 1: one-cycle `mepc` write strobe to the CSR unit.
- `trap_mepc_o` out `ADDR_W`: registered value to write to `mepc`.

## Operation
- FSM states: IDLE, WAIT_DIV, TRAP_SAVE, TRAP_JUMP, FLUSH.
- Registers: state, 3-bit flush counter, latched vector, `trap_mepc_o`.
- All other outputs are combinational from state and inputs. Each output is 0 unless it is asserted below.
- `jump_addr_o` is 0 whenever `jump_ena_o` = 0.

IDLE, resolved by priority (first match wins):
1. `irq_req_i` && !`div_busy_i`:
   - Latch `trap_mepc_o` = `ex_jump_req_i` ? `ex_jump_addr_i` : `ex_pc_i`.
   - Latch the vector from `irq_vector_i`.
   - Outputs: `irq_ack_o`, `hold_pc_o`, `flush_if_o`, `flush_id_o`. The EX jump is suppressed.
   - Next state: TRAP_SAVE.
2. `irq_req_i` && `div_busy_i`:
   - Latch the vector; pulse `irq_ack_o`.
   - Outputs: `hold_pc_o`, `hold_if_o`, `hold_id_o`.
   - Next state: WAIT_DIV.
3. `mret_req_i`:
   - `jump_ena_o` = 1, `jump_addr_o` = `mepc_i`.
   - Outputs: `flush_if_o`, `flush_id_o`. Stay in IDLE.
4. `ex_jump_req_i`:
   - `jump_ena_o` = 1, `jump_addr_o` = `ex_jump_addr_i`.
   - Outputs: `flush_if_o`, `flush_id_o`. Stay in IDLE.
5. `div_busy_i`: assert `hold_pc_o`, `hold_if_o`, `hold_id_o`.
6. `load_use_i`: assert `hold_pc_o`, `hold_if_o`, `flush_id_o` (bubble into EX).

WAIT_DIV:
- Assert `hold_pc_o`, `hold_if_o`, `hold_id_o`. The interrupt is already latched, so a drop of `irq_req_i` is ignored.
- When `div_busy_i` = 0: latch `trap_mepc_o` = `ex_pc_i` and go to TRAP_SAVE.
- All other requests are ignored.

TRAP_SAVE:
- Assert `trap_save_o`, `hold_pc_o`, `flush_if_o`, `flush_id_o`.
- Next state: TRAP_JUMP.

TRAP_JUMP:
- `jump_ena_o` = 1, `jump_addr_o` = latched vector; assert `flush_if_o`, `flush_id_o`.
- Load counter = `FLUSH_CYCLES`-1; next state: FLUSH.

FLUSH:
- Assert `flush_if_o`, `flush_id_o`, no hold. All requests are ignored.
- Counter decrements each cycle; leave for IDLE in the cycle the counter is 0.

Invariants:
- `jump_ena_o` & `hold_pc_o` is never 1.
- `irq_ack_o` pulses at most once per trap sequence.
- A new irq is not accepted before the FSM returns to IDLE.

## Timing
- Reset, asynchronous:
  - State = IDLE, counter = 0, latched vector = 0, `trap_mepc_o` = 0.
  - With idle inputs, every output is 0.
- Branch and `mret` redirect is 0-latency combinational: the PC loads the target on the same rising edge.
- Trap latency with divider idle, counting from the cycle the irq is seen in IDLE:
  - Cycle 0: accept; hold the PC.
  - Cycle 1: TRAP_SAVE.
  - Cycle 2: TRAP_JUMP; the PC equals the vector after edge 2.
  - Cycles 3..3+`FLUSH_CYCLES`-1: flush.
  - Total `FLUSH_CYCLES`+3 cycles before IDLE.
- A divider stall adds the busy cycles in WAIT_DIV before TRAP_SAVE.
- `trap_mepc_o` is stable from the cycle after the latch through TRAP_SAVE.
- Reset mid-sequence aborts immediately: no `trap_save_o` and no jump.

## Test plan
- `ex_jump_req_i` = 1, `ex_jump_addr_i` = 0x100 for one cycle -> same cycle `jump_ena_o` = 1, `jump_addr_o` = 0x100, `flush_if_o` = `flush_id_o` = 1, `hold_pc_o` = 0.
- `irq_req_i` = 1, vector 0x200, `ex_pc_i` = 0x40, no jump -> `irq_ack_o` at cycle 0; `trap_save_o` with `trap_mepc_o` = 0x40 at cycle 1; jump to 0x200 at cycle 2; flush for cycles 3-4; back to IDLE at cycle 5.
- irq together with `ex_jump_req_i` (target 0x80) -> no branch redirect; `trap_mepc_o` = 0x80.
- irq while `div_busy_i` is high for 4 cycles -> holds for 4 cycles in WAIT_DIV, then TRAP_SAVE; dropping `irq_req_i` during the wait still completes the trap.
- `load_use_i` together with `div_busy_i` -> full hold with no flush. `load_use_i` alone -> `hold_pc_o`, `hold_if_o`, `flush_id_o` only.
- `arst_n` low during TRAP_SAVE -> all outputs 0 immediately; after release, the FSM is in IDLE and `mret_req_i` with `mepc_i` = 0x300 gives a jump to 0x300.
